// File: rtl/klein_byte_frontend.sv
// Byte-serial packer/unpacker around the klein_80 block-cipher core.
// Define KLEIN_FRONTEND_CBC_EN to add CBC chaining (iv / iv_load ports and a chain register).
module klein_byte_frontend #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        ck,
  input  logic        rst,
  input  logic [0:79] key_in,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        core_start,
  output logic [0:63] core_inp,
  output logic [0:79] core_key,
  input  logic        core_ready,
  input  logic [0:63] core_out,
  output logic [7:0]  m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        busy,
`ifdef KLEIN_FRONTEND_CBC_EN
  input  logic [0:63] iv,
  input  logic        iv_load,
`endif
  output logic        timeout_err
);

  typedef enum logic [1:0] {S_FILL, S_START, S_WAIT, S_DRAIN} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  wait_q, wait_d;
  logic [63:0] inp_q, inp_d;
  logic [79:0] key_q, key_d;
  logic [63:0] out_q, out_d;
  logic        s_ready_q, s_ready_d;
  logic        start_q, start_d;
  logic        m_valid_q, m_valid_d;
  logic        busy_q, busy_d;
  logic        terr_q, terr_d;
`ifdef KLEIN_FRONTEND_CBC_EN
  logic [63:0] chain_q, chain_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wait_d    = wait_q;
    inp_d     = inp_q;
    key_d     = key_q;
    out_d     = out_q;
    s_ready_d = s_ready_q;
    start_d   = 1'b0;
    m_valid_d = m_valid_q;
    busy_d    = busy_q;
    terr_d    = terr_q;
`ifdef KLEIN_FRONTEND_CBC_EN
    chain_d   = chain_q;
`endif
    unique case (state_q)
      S_FILL: begin
`ifdef KLEIN_FRONTEND_CBC_EN
        if (iv_load && (cnt_q == 3'd0)) chain_d = iv;
`endif
        if (s_valid && s_ready_q) begin
          // Bytes shift in from the right, so the first byte lands in core_inp[0:7].
          inp_d = {inp_q[55:0], s_data};
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
`ifdef KLEIN_FRONTEND_CBC_EN
            inp_d = {inp_q[55:0], s_data} ^ chain_q;
`endif
            key_d     = key_in;
            state_d   = S_START;
            start_d   = 1'b1;
            s_ready_d = 1'b0;
            busy_d    = 1'b1;
          end
        end
      end
      S_START: begin
        wait_d  = 8'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wait_d = wait_q + 8'd1;
        // First WAIT cycle (wait_q == 0) may still see the previous block's ready level.
        if ((wait_q != 8'd0) && core_ready) begin
          out_d     = core_out;
          state_d   = S_DRAIN;
          m_valid_d = 1'b1;
`ifdef KLEIN_FRONTEND_CBC_EN
          chain_d   = core_out;
`endif
        end else if (wait_q == WAIT_LAST) begin
          out_d     = 64'd0;
          terr_d    = 1'b1;
          state_d   = S_DRAIN;
          m_valid_d = 1'b1;
        end
      end
      S_DRAIN: begin
        if (m_ready) begin
          out_d = {out_q[55:0], 8'h00};
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_d   = S_FILL;
            m_valid_d = 1'b0;
            s_ready_d = 1'b1;
            busy_d    = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      state_q   <= S_FILL;
      cnt_q     <= 3'd0;
      wait_q    <= 8'd0;
      inp_q     <= 64'd0;
      key_q     <= 80'd0;
      out_q     <= 64'd0;
      s_ready_q <= 1'b1;
      start_q   <= 1'b0;
      m_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      terr_q    <= 1'b0;
`ifdef KLEIN_FRONTEND_CBC_EN
      chain_q   <= 64'd0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wait_q    <= wait_d;
      inp_q     <= inp_d;
      key_q     <= key_d;
      out_q     <= out_d;
      s_ready_q <= s_ready_d;
      start_q   <= start_d;
      m_valid_q <= m_valid_d;
      busy_q    <= busy_d;
      terr_q    <= terr_d;
`ifdef KLEIN_FRONTEND_CBC_EN
      chain_q   <= chain_d;
`endif
    end
  end

  assign s_ready     = s_ready_q;
  assign core_start  = start_q;
  assign core_inp    = inp_q;
  assign core_key    = key_q;
  assign m_data      = out_q[63:56];
  assign m_valid     = m_valid_q;
  assign busy        = busy_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_klein_byte_frontend.sv
// Scoreboard bench for klein_byte_frontend with a behavioural stub core (out = inp ^ A5..A5).
`timescale 1ns/1ps
module tb_klein_byte_frontend;

  localparam int          TMO    = 20;
  localparam logic [63:0] STUB_X = 64'hA5A5A5A5A5A5A5A5;

  logic        ck = 1'b0;
  logic        rst;
  logic [79:0] key_in;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic        core_start;
  logic [63:0] core_inp;
  logic [79:0] core_key;
  logic        core_ready;
  logic [63:0] core_out;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic        busy;
  logic        timeout_err;
`ifdef KLEIN_FRONTEND_CBC_EN
  logic [63:0] iv;
  logic        iv_load;
`endif

  always #5 ck = ~ck;

  klein_byte_frontend #(.TIMEOUT(TMO)) dut (
    .ck          (ck),
    .rst         (rst),
    .key_in      (key_in),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .core_start  (core_start),
    .core_inp    (core_inp),
    .core_key    (core_key),
    .core_ready  (core_ready),
    .core_out    (core_out),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .busy        (busy),
`ifdef KLEIN_FRONTEND_CBC_EN
    .iv          (iv),
    .iv_load     (iv_load),
`endif
    .timeout_err (timeout_err)
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0]   exp_bytes [$];
  logic [143:0] exp_start [$];
  logic [63:0]  chain = 64'd0;
  int out_count = 0;
  int stub_mode = 0;  // 0: ready 17 cycles after start, 1: stale-high ready, 2: never ready
  int mr_mode   = 0;  // 0: always ready, 1: low 5 cycles after each byte, 2: random

  // Stub core: stub_t counts cycles since the start cycle (1 = first cycle after start).
  int          stub_t    = 0;
  logic [63:0] stub_cur  = 64'd0;
  logic [63:0] stub_prev = 64'd0;

  always @(posedge ck) begin
    if (core_start) begin
      stub_t    <= 1;
      stub_prev <= stub_cur;
      stub_cur  <= core_inp ^ STUB_X;
    end else if (stub_t > 0 && stub_t < 100000) begin
      stub_t <= stub_t + 1;
    end
  end

  always_comb begin
    core_ready = 1'b0;
    core_out   = stub_cur;
    case (stub_mode)
      0: core_ready = (stub_t == 17);
      1: begin
        core_ready = !(stub_t >= 2 && stub_t <= 4);
        if (stub_t <= 4) core_out = stub_prev;
      end
      default: core_ready = 1'b0;
    endcase
  end

  task automatic chk(input string nm, input logic [143:0] act, input logic [143:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, req);
    end
  endtask

  // Reference model: expected core inputs and output bytes for one accepted block.
  task automatic expect_block(input logic [7:0] b [0:7], input logic [79:0] key);
    logic [63:0] blk;
    logic [63:0] res;
    blk = 64'd0;
    for (int i = 0; i < 8; i++) blk = (blk << 8) | 64'(b[i]);
    blk = blk ^ chain;
    exp_start.push_back({blk, key});
    if (stub_mode == 2) begin
      res = 64'd0;
    end else begin
      res = blk ^ STUB_X;
`ifdef KLEIN_FRONTEND_CBC_EN
      chain = res;
`endif
    end
    for (int i = 0; i < 8; i++) exp_bytes.push_back(res[63 - 8*i -: 8]);
  endtask

  task automatic feed(input logic [7:0] b [0:7], input logic [79:0] key, input int n, input bit toggle);
    int i;
    int budget;
    bit ph;
    i = 0; budget = 0; ph = 1'b0;
    while (i < n) begin
      @(negedge ck);
      budget++;
      if (budget > 3000) begin
        chk("feed_timeout", i, n);
        s_valid = 1'b0;
        return;
      end
      ph      = !ph;
      s_valid = !(toggle && !ph);
      s_data  = s_valid ? b[i] : 8'($urandom());
      key_in  = (i == 7) ? key : ~key;
      if (s_valid && s_ready) begin
        i++;
        if (i == n) begin
          @(posedge ck);
          #1;
          s_valid = 1'b0;
        end
      end
    end
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while ((exp_bytes.size() != 0 || exp_start.size() != 0) && c < 5000) begin
      @(negedge ck);
      c++;
    end
    chk("drain_done", exp_bytes.size() + exp_start.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge ck);
    #1;
    rst     = 1'b1;
    s_valid = 1'b0;
    exp_bytes.delete();
    exp_start.delete();
    chain = 64'd0;
    @(posedge ck);
    #1;
    rst = 1'b0;
    @(negedge ck);
    chk("rst_s_ready", s_ready, 1'b1);
    chk("rst_core_start", core_start, 1'b0);
    chk("rst_core_inp", core_inp, 64'd0);
    chk("rst_core_key", core_key, 80'd0);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_data", m_data, 8'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_timeout_err", timeout_err, 1'b0);
  endtask

  task automatic cycles_to_mvalid(output int c);
    c = 0;
    do begin
      @(negedge ck);
      c++;
    end while (!m_valid && c < 300);
  endtask

  // Downstream ready generator.
  initial begin : mready_drv
    int stall;
    bit pv;
    stall   = 0;
    pv      = 1'b0;
    m_ready = 1'b0;
    forever begin
      @(posedge ck);
      #1;
      if (pv && m_ready) stall = 5;
      case (mr_mode)
        1: begin
          if (stall > 0) begin
            m_ready = 1'b0;
            stall--;
          end else begin
            m_ready = 1'b1;
          end
        end
        2:       m_ready = 1'($urandom_range(0, 1));
        default: m_ready = 1'b1;
      endcase
      pv = m_valid;
    end
  end

  // Monitor: pops expectations whenever the DUT presents a start pulse or an output byte.
  initial begin : monitor
    bit stalled;
    logic [7:0] held;
    logic [143:0] e;
    stalled = 1'b0;
    held    = 8'd0;
    forever begin
      @(negedge ck);
      if (rst) begin
        stalled = 1'b0;
      end else begin
        chk("busy", busy, exp_bytes.size() != 0);
        chk("s_ready", s_ready, exp_bytes.size() == 0);
        if (stalled) chk("m_data_hold", {m_valid, m_data}, {1'b1, held});
        if (core_start) begin
          if (exp_start.size() == 0) begin
            chk("unexpected_start", core_start, 1'b0);
          end else begin
            e = exp_start.pop_front();
            chk("core_inp", core_inp, e[143:80]);
            chk("core_key", core_key, e[79:0]);
          end
        end
        if (m_valid && m_ready) begin
          out_count++;
          if (exp_bytes.size() == 0) chk("extra_output", m_valid, 1'b0);
          else                       chk("m_data", m_data, exp_bytes.pop_front());
        end
        stalled = m_valid && !m_ready;
        held    = m_data;
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: time limit reached, actual still running, required finished");
    $fatal(1);
  end

  initial begin : main
    logic [7:0]  blk [0:7];
    logic [79:0] k;
    int c;
    int base;
    rst = 1'b1; s_valid = 1'b0; s_data = 8'd0; key_in = 80'd0;
`ifdef KLEIN_FRONTEND_CBC_EN
    iv = 64'd0; iv_load = 1'b0;
`endif
    repeat (2) @(posedge ck);
    do_reset();

    // Directed block with literal expectations.
    stub_mode = 0; mr_mode = 0;
    blk = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h90, 8'hAB, 8'hCD, 8'hEF};
    feed(blk, {80{1'b1}}, 8, 1'b0);
    exp_start.push_back({64'h1234567890abcdef, {80{1'b1}}});
    blk = '{8'hB7, 8'h91, 8'hF3, 8'hDD, 8'h35, 8'h0E, 8'h68, 8'h4A};
    for (int i = 0; i < 8; i++) exp_bytes.push_back(blk[i]);
    cycles_to_mvalid(c);
    chk("capture_latency", c, 19);
    wait_idle();

`ifdef KLEIN_FRONTEND_CBC_EN
    @(negedge ck);
    iv = 64'h0123456789abcdef; iv_load = 1'b1;
    @(negedge ck);
    iv_load = 1'b0;
    chain = 64'h0123456789abcdef;
    blk = '{default: 8'h00};
    for (int r = 0; r < 2; r++) begin
      feed(blk, 80'h0, 8, 1'b0);
      expect_block(blk, 80'h0);
      wait_idle();
    end
`endif

    // Backpressure on both sides.
    mr_mode = 1;
    for (int r = 0; r < 4; r++) begin
      foreach (blk[i]) blk[i] = 8'($urandom());
      k = {$urandom(), $urandom(), 16'($urandom())};
      feed(blk, k, 8, 1'b1);
      expect_block(blk, k);
    end
    wait_idle();

    // Stale ready level carried over from the previous block.
    stub_mode = 1; mr_mode = 2;
    for (int r = 0; r < 3; r++) begin
      foreach (blk[i]) blk[i] = 8'($urandom());
      k = {$urandom(), $urandom(), 16'($urandom())};
      feed(blk, k, 8, 1'b0);
      expect_block(blk, k);
      if (r == 1) begin
        cycles_to_mvalid(c);
        chk("stale_capture_latency", c, 7);
      end
    end
    wait_idle();

    // Core never answers.
    stub_mode = 2; mr_mode = 0;
    foreach (blk[i]) blk[i] = 8'($urandom());
    k = {$urandom(), $urandom(), 16'($urandom())};
    feed(blk, k, 8, 1'b0);
    expect_block(blk, k);
    for (c = 1; c <= 21; c++) @(negedge ck);
    chk("timeout_not_early", timeout_err, 1'b0);
    @(negedge ck);
    chk("timeout_set", timeout_err, 1'b1);
    wait_idle();
    stub_mode = 0;
    foreach (blk[i]) blk[i] = 8'($urandom());
    feed(blk, k, 8, 1'b0);
    expect_block(blk, k);
    wait_idle();
    chk("timeout_sticky", timeout_err, 1'b1);
    do_reset();

    // Reset mid-fill, mid-wait and mid-drain, each followed by a clean block.
    for (int sc = 0; sc < 3; sc++) begin
      foreach (blk[i]) blk[i] = 8'($urandom());
      k = {$urandom(), $urandom(), 16'($urandom())};
      mr_mode = (sc == 2) ? 1 : 0;
      if (sc == 0) begin
        feed(blk, k, 5, 1'b0);
      end else begin
        feed(blk, k, 8, 1'b0);
        expect_block(blk, k);
        if (sc == 1) begin
          repeat (4) @(negedge ck);
        end else begin
          base = out_count;
          c = 0;
          while (out_count < base + 3 && c < 500) begin
            @(negedge ck);
            c++;
          end
          chk("drain_progress", out_count - base, 3);
        end
      end
      do_reset();
      mr_mode = 0;
      foreach (blk[i]) blk[i] = 8'($urandom());
      k = {$urandom(), $urandom(), 16'($urandom())};
      feed(blk, k, 8, 1'b0);
      expect_block(blk, k);
      wait_idle();
    end

    // Random traffic.
    mr_mode = 2;
    for (int r = 0; r < 4; r++) begin
      foreach (blk[i]) blk[i] = 8'($urandom());
      k = {$urandom(), $urandom(), 16'($urandom())};
      feed(blk, k, 8, 1'($urandom_range(0, 1)));
      expect_block(blk, k);
    end
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/klein_byte_frontend.md
Name: klein_byte_frontend

Overview:
- Byte-serial front/back end for the klein_80 block-cipher core.
- Upstream side: accepts plaintext one byte at a time over a valid/ready handshake and packs 8 bytes into a 64-bit block.
- Core side: drives the core's start/inp/key inputs, waits for the core's ready, then captures the 64-bit result.
- Downstream side: emits the result one byte at a time over a valid/ready handshake.

Parameters:
- TIMEOUT, 255, maximum cycles to wait for core_ready after a start pulse before flagging an error (1..255).

Ports:
- ck  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- key_in  input  [0:79]  cipher key; sampled into the key register on the cycle the 8th input byte is accepted
- s_data  input  [7:0]  plaintext byte; first byte maps to inp[0:7], eighth to inp[56:63]
- s_valid  input  1  s_data valid
- s_ready  output  1  frontend can accept a byte
- core_start  output  1  one-cycle start pulse to the core
- core_inp  output  [0:63]  block to the core, held stable from start until capture
- core_key  output  [0:79]  key to the core, held stable from start until capture
- core_ready  input  1  core result valid
- core_out  input  [0:63]  core result
- m_data  output  [7:0]  ciphertext byte, core_out[0:7] first
- m_valid  output  1  m_data valid
- m_ready  input  1  downstream accepts m_data
- busy  output  1  high in any state other than FILL
- timeout_err  output  1  sticky; set on timeout, cleared only by rst

Behaviour:
- Reset values (rst high at a rising edge): state=FILL, byte count=0, s_ready=1, core_start=0, core_inp=0, core_key=0, m_valid=0, m_data=0, busy=0, timeout_err=0. Reset applied mid-operation aborts the block in progress; partial data is discarded.
- FILL:
  - s_ready=1.
  - A byte transfers on s_valid&s_ready. It is shifted into core_inp at position count, and count increments.
  - On the 8th transfer (count=7): latch key_in into core_key, count→0, go to START.
- START:
  - core_start=1 for exactly this one cycle; s_ready=0.
  - The wait counter clears; go to WAIT.
- WAIT:
  - core_ready is ignored in the first WAIT cycle, because a stale ready from the previous block may still be high.
  - From the 2nd WAIT cycle on, the first cycle with core_ready=1 captures core_out into the output shift register and goes to DRAIN.
  - Latency: the earliest capture is 2 cycles after the core_start cycle.
  - If the wait counter reaches TIMEOUT without a capture: set timeout_err, load an all-zero output block, go to DRAIN. The downstream byte count therefore always stays consistent.
- DRAIN:
  - m_valid=1 and m_data=byte[count].
  - A byte transfers on m_valid&m_ready. The register shifts left 8 bits and count increments.
  - m_data holds stable while m_ready=0.
  - After the 8th transfer: m_valid=0, count→0, go to FILL. s_ready=1 on the next cycle.
- Input and output are not overlapped: s_ready=0 in START, WAIT and DRAIN.
- s_valid with no transfer in FILL, or m_ready with m_valid=0, has no effect.
- core_inp/core_key are not modified outside FILL→START. They stay valid while the core computes.

Optional Feature:
- Macro: KLEIN_FRONTEND_CBC_EN.
- Defined (CBC mode):
  - Adds ports iv  input  [0:63] and iv_load  input  1.
  - A 64-bit chain register is reset to 0 and loaded from iv when iv_load=1 in FILL with count=0. iv_load in any other state is ignored.
  - The block sent to the core is the assembled block XOR chain. XOR is applied at the FILL→START transition.
  - On capture, chain←core_out. On timeout, chain is unchanged.
- Not defined: no iv/iv_load ports, no chain register; the assembled block passes through unmodified (ECB).

Test Plan:
- Basic ECB, stub core (ready 17 cycles after start, out=inp XOR 64'hA5A5A5A5A5A5A5A5):
  - Stimulus: feed bytes 12 34 56 78 90 AB CD EF with key_in=80'hFFFFFFFFFFFFFFFFFFFF, m_ready=1.
  - Required: one core_start pulse, core_inp=64'h1234567890abcdef, core_key=all-ones.
  - Output bytes: B7 91 F3 DD 35 0E 68 4A.
- Real core:
  - Stimulus: connect klein_80; send (key 0, pt 64'h1234567890abcdef), then (key all-ones, pt 0).
  - Required: m_data bytes equal the golden-model ciphertext, MSB byte first.
- Backpressure:
  - Stimulus: s_valid toggling 1/0 every cycle on input; m_ready low for 5 cycles after each output byte.
  - Required: correct byte order, m_data stable while stalled, exactly 8 outputs, s_ready=0 until the last output is accepted.
- Stale ready and timeout:
  - Stimulus 1: stub holds core_ready=1 continuously from the previous block, then drops it for 3 cycles and raises it.
  - Required 1: capture happens on the re-raise, not the stale level.
  - Stimulus 2: stub never raises ready, TIMEOUT=20.
  - Required 2: timeout_err=1 exactly 20 WAIT cycles after entry, eight 00 bytes output, FILL resumes.
- Reset mid-operation:
  - Stimulus: assert rst after 5 input bytes, and separately during WAIT and during DRAIN (after 3 output bytes).
  - Required: every output at its reset value on the next cycle; the following full block encrypts correctly.
- CBC (macro defined):
  - Stimulus: iv=64'h0123456789abcdef, stub core, two identical blocks 00…00.
  - Required: first core_inp=64'h0123456789abcdef; second core_inp=first stub output; outputs differ.
